// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// configurable payload/parity/stop, one-entry holding register with valid/ready.
module uart_rx_param #(
  parameter int CYCLES_PER_BIT = 5000,
  parameter int PAYLOAD_BITS   = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  input  logic                    uart_rx_ready,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_parity_err,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break,
  output logic                    uart_rx_overrun,
  output logic                    uart_rx_busy
);

  if (CYCLES_PER_BIT < 8 || CYCLES_PER_BIT > 65535 ||
      PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_rx_param: illegal parameter value");
  end

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic ODD_PARITY = (PARITY_MODE == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic maj3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
  endfunction

  function automatic logic parity_of(input logic [PAYLOAD_BITS-1:0] d, input logic pb);
    return (^d) ^ pb;
  endfunction

  state_t state, state_next;
  logic rxd_p0, rxd_s;
  logic [2:0] hist;
  logic bit_s;
  logic [CNT_W-1:0] cnt;
  logic [3:0] bit_cnt;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic fe_acc, pe_acc, fe_final;
  logic sample, frame_done;

  // Stage p0/p1: synchroniser, then 3-deep history feeding the majority vote
  always_ff @(posedge clk) begin
    if (!resetn || !uart_rx_en) begin
      rxd_p0 <= 1'b1;
      rxd_s  <= 1'b1;
      hist   <= 3'b111;
    end else begin
      rxd_p0 <= uart_rxd;
      rxd_s  <= rxd_p0;
      hist   <= {hist[1:0], rxd_s};
    end
  end

  assign bit_s = maj3(hist);

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!uart_rx_en) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (!rxd_s) state_next = S_START;
        S_START:  if (sample) state_next = bit_s ? S_IDLE : S_DATA;
        S_DATA:   if (sample && bit_cnt == DATA_LAST)
                    state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        S_PARITY: if (sample) state_next = S_STOP;
        S_STOP:   if (sample && bit_cnt == STOP_LAST) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    uart_rx_busy = (state != S_IDLE);
    sample       = 1'b0;
    case (state)
      S_START:                  sample = (cnt == HALF_CNT);
      S_DATA, S_PARITY, S_STOP: sample = (cnt == FULL_CNT);
      default:                  sample = 1'b0;
    endcase
    frame_done = uart_rx_en && (state == S_STOP) && sample && (bit_cnt == STOP_LAST);
  end

  // Stage p2: bit timing, payload assembly and per-frame status accumulation
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= '0;
      bit_cnt <= '0;
      fe_acc  <= 1'b0;
      pe_acc  <= 1'b0;
    end else begin
      if (state_next != state || sample) cnt <= '0;
      else if (state != S_IDLE)          cnt <= cnt + CNT_W'(1);
      if (state_next != state) bit_cnt <= '0;
      else if (sample)         bit_cnt <= bit_cnt + 4'd1;
      if (state == S_IDLE) begin
        fe_acc <= 1'b0;
        pe_acc <= 1'b0;
      end else if (sample) begin
        if (state == S_PARITY) pe_acc <= parity_of(shreg, bit_s) != ODD_PARITY;
        if (state == S_STOP)   fe_acc <= fe_acc | ~bit_s;
      end
    end
  end

  // Every payload bit is overwritten before use, so the shifter needs no reset
  always_ff @(posedge clk) begin
    if (state == S_DATA && sample) shreg <= {bit_s, shreg[PAYLOAD_BITS-1:1]};
  end

  assign fe_final = fe_acc | ~bit_s;

  // Stage p3: holding register and handshake
  always_ff @(posedge clk) begin
    if (!resetn) begin
      uart_rx_valid      <= 1'b0;
      uart_rx_data       <= '0;
      uart_rx_parity_err <= 1'b0;
      uart_rx_frame_err  <= 1'b0;
      uart_rx_break      <= 1'b0;
      uart_rx_overrun    <= 1'b0;
    end else begin
      uart_rx_overrun <= 1'b0;
      if (frame_done && (!uart_rx_valid || uart_rx_ready)) begin
        uart_rx_valid      <= 1'b1;
        uart_rx_data       <= shreg;
        uart_rx_parity_err <= pe_acc;
        uart_rx_frame_err  <= fe_final;
        uart_rx_break      <= (shreg == '0) && fe_final;
      end else begin
        if (frame_done) uart_rx_overrun <= 1'b1;
        if (uart_rx_valid && uart_rx_ready) uart_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Bench for uart_rx_param: four instances (8N1, even parity, odd parity, 2 stop bits)
// driven on separate serial lines and checked against a frame-level reference model.
module tb_uart_rx_param;
  localparam int CPB = 16;
  localparam int N   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, en, ready;
  logic [N-1:0] rxd, valid, pe, fe, brk, ov, busy;
  logic [7:0] data_o [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_rx_param #(
      .CYCLES_PER_BIT(CPB),
      .PAYLOAD_BITS  (8),
      .PARITY_MODE   (g == 1 ? 1 : (g == 2 ? 2 : 0)),
      .STOP_BITS     (g == 3 ? 2 : 1)
    ) u_dut (
      .clk               (clk),
      .resetn            (resetn),
      .uart_rxd          (rxd[g]),
      .uart_rx_en        (en),
      .uart_rx_ready     (ready),
      .uart_rx_valid     (valid[g]),
      .uart_rx_data      (data_o[g]),
      .uart_rx_parity_err(pe[g]),
      .uart_rx_frame_err (fe[g]),
      .uart_rx_break     (brk[g]),
      .uart_rx_overrun   (ov[g]),
      .uart_rx_busy      (busy[g])
    );
  end

  int checks = 0;
  int passes = 0;

  // Accepted frames as {instance, data, parity_err, frame_err, break}
  logic [12:0] got_q[$];
  logic [12:0] exp_q[$];
  int ov_cnt [N];
  int ov_base [N];
  int got_base;
  logic [23:0] rst_flags;
  logic [31:0] rst_data;

  initial for (int g = 0; g < N; g++) ov_cnt[g] = 0;

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (resetn && valid[g] && ready)
        got_q.push_back({2'(g), data_o[g], pe[g], fe[g], brk[g]});
      if (ov[g]) ov_cnt[g] = ov_cnt[g] + 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int nbits);
    rxd = '1;
    repeat (nbits * CPB) tick();
  endtask

  task automatic clear_log();
    got_base = got_q.size();
    exp_q.delete();
    for (int g = 0; g < N; g++) ov_base[g] = ov_cnt[g];
  endtask

  // Reference: what a receiver must report for a well-timed frame
  function automatic logic [12:0] model_frame(input int idx, input logic [7:0] d,
                                              input logic pb, input logic [1:0] stop_lv);
    int pm;
    int ns;
    int ones;
    logic p_e, f_e;
    pm   = (idx == 1) ? 1 : ((idx == 2) ? 2 : 0);
    ns   = (idx == 3) ? 2 : 1;
    ones = $countones(d) + int'(pb);
    p_e  = (pm == 1) ? (ones % 2 != 0) : ((pm == 2) ? (ones % 2 != 1) : 1'b0);
    f_e  = !stop_lv[0] || (ns == 2 && !stop_lv[1]);
    return {idx[1:0], d, p_e, f_e, (d == 8'h00) && f_e};
  endfunction

  // Drives one frame on line idx; optional one-cycle glitch, enable drop or reset
  task automatic send_frame(input int idx, input logic [7:0] d, input logic pb,
                            input int glitch_bit, input int en_bit, input int rst_bit);
    logic bits [12];
    int nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    nb = 9;
    if (idx == 1 || idx == 2) begin
      bits[nb] = pb;
      nb = nb + 1;
    end
    bits[nb] = 1'b1;
    nb = nb + 1;
    if (idx == 3) begin
      bits[nb] = 1'b1;
      nb = nb + 1;
    end
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < CPB; j++) begin
        rxd[idx] = (b == glitch_bit && j == 6) ? ~bits[b] : bits[b];
        en       = !(b == en_bit && j == 8);
        resetn   = !(b == rst_bit && j == 8);
        tick();
        if (b == rst_bit && j == 8) begin
          rst_flags = {valid, pe, fe, brk, ov, busy};
          rst_data  = {data_o[0], data_o[1], data_o[2], data_o[3]};
        end
      end
    end
    rxd[idx] = 1'b1;
    en       = 1'b1;
    resetn   = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    for (int g = 0; g < N; g++) begin
      checks++;
      if ({valid[g], pe[g], fe[g], brk[g], ov[g], busy[g], data_o[g]} !== 14'h0)
        $display("FAIL reset_outputs[%0d]: got %h, expected 0", g,
                 {valid[g], pe[g], fe[g], brk[g], ov[g], busy[g], data_o[g]});
      else passes++;
    end
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_8n1();
    logic [7:0] d;
    clear_log();
    ready = 1'b1;
    send_frame(0, 8'hA5, 1'b0, -1, -1, -1);
    exp_q.push_back(model_frame(0, 8'hA5, 1'b0, 2'b11));
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      send_frame(0, d, 1'b0, -1, -1, -1);
      exp_q.push_back(model_frame(0, d, 1'b0, 2'b11));
      idle($urandom_range(0, 2));
    end
    idle(3);
    checks++;
    if (got_q.size() - got_base != exp_q.size())
      $display("FAIL 8n1_count: got %0d frames, expected %0d", got_q.size() - got_base, exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      checks++;
      if (got_q[got_base + i] !== exp_q[i])
        $display("FAIL 8n1_frame[%0d]: got %h, expected %h", i, got_q[got_base + i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (ov_cnt[0] - ov_base[0] != 0)
      $display("FAIL 8n1_overrun: got %0d pulses, expected 0", ov_cnt[0] - ov_base[0]);
    else passes++;
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic pb;
    clear_log();
    ready = 1'b1;
    for (int idx = 1; idx <= 2; idx++) begin
      for (int k = 0; k < 6; k++) begin
        d  = (k < 2) ? 8'h03 : 8'($urandom);
        pb = (k < 2) ? k[0] : 1'($urandom);
        send_frame(idx, d, pb, -1, -1, -1);
        exp_q.push_back(model_frame(idx, d, pb, 2'b11));
      end
    end
    idle(3);
    checks++;
    if (got_q.size() - got_base != exp_q.size())
      $display("FAIL parity_count: got %0d frames, expected %0d", got_q.size() - got_base, exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      checks++;
      if (got_q[got_base + i] !== exp_q[i])
        $display("FAIL parity_frame[%0d]: got %h, expected %h", i, got_q[got_base + i], exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_false_start();
    clear_log();
    rxd[0] = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy[0] !== 1'b1) $display("FAIL false_start_busy_rise: got %b, expected 1", busy[0]);
    else passes++;
    tick();
    rxd[0] = 1'b1;
    repeat (20) tick();
    checks++;
    if (busy[0] !== 1'b0) $display("FAIL false_start_busy_drop: got %b, expected 0", busy[0]);
    else passes++;
    idle(2);
    checks++;
    if (got_q.size() != got_base)
      $display("FAIL false_start_frames: got %0d frames, expected 0", got_q.size() - got_base);
    else passes++;
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    int gb;
    clear_log();
    ready = 1'b1;
    send_frame(0, 8'h00, 1'b0, 4, -1, -1);
    exp_q.push_back(model_frame(0, 8'h00, 1'b0, 2'b11));
    for (int k = 0; k < 3; k++) begin
      d  = 8'($urandom);
      gb = $urandom_range(1, 8);
      send_frame(0, d, 1'b0, gb, -1, -1);
      exp_q.push_back(model_frame(0, d, 1'b0, 2'b11));
    end
    idle(3);
    checks++;
    if (got_q.size() - got_base != exp_q.size())
      $display("FAIL glitch_count: got %0d frames, expected %0d", got_q.size() - got_base, exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      checks++;
      if (got_q[got_base + i] !== exp_q[i])
        $display("FAIL glitch_frame[%0d]: got %h, expected %h", i, got_q[got_base + i], exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_break();
    logic [12:0] want;
    clear_log();
    ready = 1'b1;
    rxd[3] = 1'b0;
    repeat (12 * CPB) tick();
    rxd[3] = 1'b1;
    idle(30);
    want = model_frame(3, 8'h00, 1'b0, 2'b00);
    checks++;
    if (got_q.size() == got_base)
      $display("FAIL break_count: got 0 frames, expected at least 1");
    else passes++;
    if (got_q.size() > got_base) begin
      checks++;
      if (got_q[got_base] !== want)
        $display("FAIL break_frame: got %h, expected %h", got_q[got_base], want);
      else passes++;
    end
  endtask

  task automatic test_overrun();
    clear_log();
    ready = 1'b0;
    send_frame(0, 8'h11, 1'b0, -1, -1, -1);
    send_frame(0, 8'h22, 1'b0, -1, -1, -1);
    idle(2);
    checks++;
    if (valid[0] !== 1'b1) $display("FAIL overrun_valid_held: got %b, expected 1", valid[0]);
    else passes++;
    checks++;
    if (data_o[0] !== 8'h11) $display("FAIL overrun_data_held: got %h, expected 11", data_o[0]);
    else passes++;
    checks++;
    if (ov_cnt[0] - ov_base[0] != 1)
      $display("FAIL overrun_pulse: got %0d cycles, expected 1", ov_cnt[0] - ov_base[0]);
    else passes++;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (valid[0] !== 1'b0) $display("FAIL overrun_valid_clear: got %b, expected 0", valid[0]);
    else passes++;
    exp_q.push_back(model_frame(0, 8'h11, 1'b0, 2'b11));
    checks++;
    if (got_q.size() - got_base != 1 || got_q[got_base] !== exp_q[0])
      $display("FAIL overrun_accepted: got %0d frames (first %h), expected 1 frame %h",
               got_q.size() - got_base, (got_q.size() > got_base) ? got_q[got_base] : 13'h0, exp_q[0]);
    else passes++;
    ready = 1'b1;
    idle(1);
  endtask

  task automatic test_enable();
    clear_log();
    ready = 1'b1;
    send_frame(0, 8'hFF, 1'b0, -1, 3, -1);
    send_frame(0, 8'h5A, 1'b0, -1, -1, -1);
    exp_q.push_back(model_frame(0, 8'h5A, 1'b0, 2'b11));
    idle(3);
    checks++;
    if (got_q.size() - got_base != 1 || got_q[got_base] !== exp_q[0])
      $display("FAIL enable_frames: got %0d frames (first %h), expected 1 frame %h",
               got_q.size() - got_base, (got_q.size() > got_base) ? got_q[got_base] : 13'h0, exp_q[0]);
    else passes++;
    checks++;
    if (ov_cnt[0] - ov_base[0] != 0)
      $display("FAIL enable_overrun: got %0d pulses, expected 0", ov_cnt[0] - ov_base[0]);
    else passes++;
  endtask

  task automatic test_reset_mid();
    clear_log();
    ready = 1'b0;
    send_frame(0, 8'h33, 1'b0, -1, -1, -1);
    idle(1);
    checks++;
    if (valid[0] !== 1'b1) $display("FAIL reset_mid_precond: got valid %b, expected 1", valid[0]);
    else passes++;
    send_frame(0, 8'hF0, 1'b0, -1, -1, 6);
    checks++;
    if (rst_flags !== 24'h0) $display("FAIL reset_mid_flags: got %h, expected 0", rst_flags);
    else passes++;
    checks++;
    if (rst_data !== 32'h0) $display("FAIL reset_mid_data: got %h, expected 0", rst_data);
    else passes++;
    ready = 1'b1;
    idle(1);
    send_frame(0, 8'h7E, 1'b0, -1, -1, -1);
    exp_q.push_back(model_frame(0, 8'h7E, 1'b0, 2'b11));
    idle(3);
    checks++;
    if (got_q.size() - got_base != 1 || got_q[got_base] !== exp_q[0])
      $display("FAIL reset_mid_next: got %0d frames (first %h), expected 1 frame %h",
               got_q.size() - got_base, (got_q.size() > got_base) ? got_q[got_base] : 13'h0, exp_q[0]);
    else passes++;
  endtask

  initial begin
    resetn = 1'b0;
    en     = 1'b1;
    ready  = 1'b1;
    rxd    = '1;
    got_base = 0;
    for (int g = 0; g < N; g++) ov_base[g] = 0;
    rst_flags = '0;
    rst_data  = '0;
    test_reset();
    test_8n1();
    test_parity();
    test_false_start();
    test_glitch();
    test_break();
    test_overrun();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 receiver in the UART subsystem. It adds configurable payload width, parity and stop bits, majority-vote bit sampling, and false-start rejection. A one-entry output holding register with a valid/ready handshake carries per-frame parity, framing and break status, plus an overrun indication. It sits between the pad-side serial input and the bus-side RX data consumer.

Parameters:
CYCLES_PER_BIT, 5000, clk cycles per serial bit; legal range 8 to 65535.
PAYLOAD_BITS, 8, data bits per frame; legal range 5 to 9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits checked per frame; 1 or 2.

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
uart_rxd  input  1  asynchronous serial input, idle high
uart_rx_en  input  1  receiver enable
uart_rx_ready  input  1  consumer accepts the held frame
uart_rx_valid  output  1  holding register holds an unconsumed frame
uart_rx_data  output  PAYLOAD_BITS  received payload, right-aligned, first bit received in bit 0
uart_rx_parity_err  output  1  parity mismatch for the held frame; always 0 when PARITY_MODE = 0
uart_rx_frame_err  output  1  a stop bit sampled 0 for the held frame
uart_rx_break  output  1  held frame has all-zero data and frame_err = 1
uart_rx_overrun  output  1  one-cycle pulse when a completed frame is dropped
uart_rx_busy  output  1  FSM not in IDLE

Behaviour:
- Reset (resetn = 0 at a clk edge): FSM to IDLE; synchroniser and majority history to all 1s; counters to 0; every output to 0 (uart_rx_data = 0).
- Synchroniser: two flops on uart_rxd, giving rxd_s. A 3-deep history of rxd_s shifts every cycle. The sampled bit is the majority of the 3 history values.
- uart_rx_en = 0: synchroniser and history load 1; FSM returns to IDLE on the next edge, abandoning any partial frame with no flags raised. The holding register and handshake continue to operate.
- Cycle counter: width clog2(CYCLES_PER_BIT). Cleared on every state entry and on every bit sample; increments otherwise in non-IDLE states.
- FSM states and transitions:
  - IDLE: rxd_s = 0 -> START.
  - START: sample when counter = CYCLES_PER_BIT/2 - 1. Sample 1 -> IDLE (false start, no output). Sample 0 -> DATA.
  - DATA: sample when counter = CYCLES_PER_BIT - 1, once per bit for PAYLOAD_BITS bits. Each sample shifts into the MSB of the shift register, which shifts right. After the last bit -> PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: one sample at CYCLES_PER_BIT - 1. Error when XOR(data, parity bit) is not 0 (even mode) or not 1 (odd mode). -> STOP.
  - STOP: sample at CYCLES_PER_BIT - 1 for each of STOP_BITS bits; frame_err accumulates as OR of (sample == 0). After the last stop sample, the frame completes and the FSM goes to IDLE the same edge. Completion is mid-stop-bit, so a back-to-back start bit is caught.
- Completion commit (same edge as the last stop sample):
  - Holding register empty, or uart_rx_valid && uart_rx_ready this cycle: load data and status; uart_rx_valid = 1 from the next cycle.
  - Otherwise: the new frame is discarded, the held frame is untouched, and uart_rx_overrun pulses high for exactly 1 cycle.
- Handshake: uart_rx_valid stays high and data/status stay stable until a cycle with uart_rx_ready = 1. uart_rx_valid clears on the following edge unless a completion loads a new frame on that edge. uart_rx_ready while valid = 0 is ignored.
- Latency: the pad edge reaches rxd_s after 2 cycles; the majority adds 1 cycle of effective delay.
- Illegal parameter values: not supported; the elaboration-time check must fail.

Test Plan:
- 8N1, CYCLES_PER_BIT = 16, ready tied 1, send 0xA5 -> exactly one valid pulse; data = 0xA5; parity_err = frame_err = break = overrun = 0.
- PARITY_MODE = 1: send 0x03 with parity bit 0 -> parity_err = 0. Resend with parity bit 1 -> data = 0x03, parity_err = 1. Repeat with PARITY_MODE = 2 -> inverse results.
- Start-bit low pulse of 5 cycles (< CYCLES_PER_BIT/2), then idle -> FSM returns to IDLE; busy drops; no valid.
- Single-cycle glitch to 1 in the middle of data bit 3 of 0x00 -> majority rejects it; data = 0x00.
- STOP_BITS = 2, all line low for 12 bit times -> data = 0x00, frame_err = 1, break = 1.
- Ready held 0; send 0x11 then 0x22 back-to-back -> data holds 0x11; overrun is a 1-cycle pulse at the 0x22 completion; after ready = 1 for 1 cycle, valid = 0.
- Mid-frame uart_rx_en = 0 for 1 cycle -> no valid or overrun for that frame; the next full frame 0x5A is received correctly.
- Reset asserted mid-DATA -> all outputs 0 on the next edge; a subsequent frame 0x7E is received correctly.
